// File: rtl/mtl_bus_pkg.sv
// Shared types and MTL-1 memory map constants for the 6809 bus bridge.
package mtl_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DRIVE
    } state_t;

    localparam logic [15:0] SRAM_BASE = 16'h0000;
    localparam logic [15:0] SRAM_MASK = 16'hF000;
    localparam logic [15:0] IOX_BASE  = 16'hA000;
    localparam logic [15:0] IOX_MASK  = 16'hE000;
    localparam logic [15:0] UART_BASE = 16'hA000;
    localparam logic [15:0] UART_MASK = 16'hFFF0;
    localparam logic [15:0] ROM_BASE  = 16'hF000;
    localparam logic [15:0] ROM_MASK  = 16'hF000;

    // Region 0 lands in the least significant slice of the packed vector.
    function automatic logic [63:0] pack_map(input logic [15:0] r0, input logic [15:0] r1,
                                             input logic [15:0] r2, input logic [15:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    localparam logic [63:0] DEFAULT_BASE = pack_map(SRAM_BASE, IOX_BASE, UART_BASE, ROM_BASE);
    localparam logic [63:0] DEFAULT_MASK = pack_map(SRAM_MASK, IOX_MASK, UART_MASK, ROM_MASK);

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for an asynchronous level, with single-cycle rise/fall pulses.
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/mtl_bus_bridge.sv
// MTL-1 6809 bus bridge: region decode, MRDY stretching, registered read drive,
// write capture on E fall and timeout recovery.
module mtl_bus_bridge
    import mtl_bus_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEFAULT_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = DEFAULT_MASK,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SYNC_STAGES = 2,
    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             i_ADDRESS_BUS,
    input  logic                          i_RW,
    input  logic                          i_E,
    input  logic                          i_Q,
    input  logic [DATA_W-1:0]             i_data_bus,
    output logic [DATA_W-1:0]             o_data_bus,
    output logic                          o_data_oe,
    output logic                          o_DBEN,
    output logic                          o_MRDY,
    output logic [NUM_REGIONS-1:0]        o_ce,
    output logic [NUM_REGIONS-1:0]        o_wr_strobe,
    output logic [DATA_W-1:0]             o_wdata,
    input  logic [NUM_REGIONS-1:0]        i_ready,
    input  logic [NUM_REGIONS*DATA_W-1:0] i_rdata,
    output logic [IDX_W-1:0]              o_region_idx,
    output logic                          o_timeout_err,
    input  logic                          i_err_clr
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic w_e_level, w_e_rise, w_e_fall;
    logic w_q_level, w_q_rise, w_q_fall;

    edge_sync #(.STAGES(SYNC_STAGES)) u_sync_e (
        .clk(clk), .reset(reset), .i_async(i_E),
        .o_level(w_e_level), .o_rise(w_e_rise), .o_fall(w_e_fall)
    );

    edge_sync #(.STAGES(SYNC_STAGES)) u_sync_q (
        .clk(clk), .reset(reset), .i_async(i_Q),
        .o_level(w_q_level), .o_rise(w_q_rise), .o_fall(w_q_fall)
    );

    state_t                   r_state, w_state_n;
    logic                     r_rw, w_rw_n;
    logic [IDX_W-1:0]         r_idx, w_idx_n;
    logic [CNT_W-1:0]         r_cnt, w_cnt_n;
    logic                     r_timed_out, w_timed_out_n;
    logic [DATA_W-1:0]        r_shadow, w_shadow_n;
    logic [NUM_REGIONS-1:0]   r_ce, w_ce_n;
    logic [NUM_REGIONS-1:0]   r_strobe, w_strobe_n;
    logic [DATA_W-1:0]        r_wdata, w_wdata_n;
    logic [DATA_W-1:0]        r_data, w_data_n;
    logic                     r_oe, w_oe_n;
    logic                     r_dben, w_dben_n;
    logic                     r_mrdy, w_mrdy_n;
    logic                     r_err, w_err_n;

    logic                     w_hit;
    logic [IDX_W-1:0]         w_hit_idx;
    logic                     w_ready;
    logic [DATA_W-1:0]        w_rslice;

    // Scan from the top down so the lowest matching region is the one left standing.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((i_ADDRESS_BUS & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    assign w_ready  = i_ready[r_idx];
    assign w_rslice = i_rdata[int'(r_idx)*DATA_W +: DATA_W];

    always_comb begin
        w_state_n     = r_state;
        w_rw_n        = r_rw;
        w_idx_n       = r_idx;
        w_cnt_n       = r_cnt;
        w_timed_out_n = r_timed_out;
        w_shadow_n    = r_shadow;
        w_ce_n        = r_ce;
        w_strobe_n    = '0;
        w_wdata_n     = r_wdata;
        w_data_n      = r_data;
        w_oe_n        = r_oe;
        w_dben_n      = r_dben;
        w_mrdy_n      = r_mrdy;
        w_err_n       = r_err & ~i_err_clr;

        case (r_state)
            IDLE: begin
                w_ce_n   = '0;
                w_oe_n   = 1'b0;
                w_dben_n = 1'b1;
                w_mrdy_n = 1'b1;
                if (w_q_rise && w_hit) begin
                    w_state_n     = ACCESS;
                    w_rw_n        = i_RW;
                    w_idx_n       = w_hit_idx;
                    w_cnt_n       = '0;
                    w_timed_out_n = 1'b0;
                    w_ce_n        = NUM_REGIONS'(1) << w_hit_idx;
                    w_mrdy_n      = 1'b0;
                end
            end

            ACCESS: begin
                w_cnt_n = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
                if (w_e_level && !r_rw) begin
                    w_shadow_n = i_data_bus;
                end
                // Ready is tested first so a late ready on the final count still completes cleanly.
                if (w_ready) begin
                    if (r_rw) begin
                        w_data_n = w_rslice;
                    end
                    w_mrdy_n  = 1'b1;
                    w_oe_n    = r_rw;
                    w_dben_n  = ~r_rw;
                    w_state_n = DRIVE;
                end else if (w_cnt_n == CNT_MAX) begin
                    if (r_rw) begin
                        w_data_n = '1;
                    end
                    w_err_n       = 1'b1;
                    w_timed_out_n = 1'b1;
                    w_mrdy_n      = 1'b1;
                    w_oe_n        = r_rw;
                    w_dben_n      = ~r_rw;
                    w_state_n     = DRIVE;
                end
            end

            DRIVE: begin
                if (!r_rw && w_e_level) begin
                    w_shadow_n = i_data_bus;
                end
                // o_ce stays up through the strobe cycle and is dropped by IDLE one clock later.
                if (w_e_fall) begin
                    if (!r_rw && !r_timed_out) begin
                        w_wdata_n  = r_shadow;
                        w_strobe_n = r_ce;
                    end
                    w_oe_n    = 1'b0;
                    w_dben_n  = 1'b1;
                    w_state_n = IDLE;
                end
            end

            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rw        <= 1'b1;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
            r_shadow    <= '0;
            r_ce        <= '0;
            r_strobe    <= '0;
            r_wdata     <= '0;
            r_data      <= '0;
            r_oe        <= 1'b0;
            r_dben      <= 1'b1;
            r_mrdy      <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_rw        <= w_rw_n;
            r_idx       <= w_idx_n;
            r_cnt       <= w_cnt_n;
            r_timed_out <= w_timed_out_n;
            r_shadow    <= w_shadow_n;
            r_ce        <= w_ce_n;
            r_strobe    <= w_strobe_n;
            r_wdata     <= w_wdata_n;
            r_data      <= w_data_n;
            r_oe        <= w_oe_n;
            r_dben      <= w_dben_n;
            r_mrdy      <= w_mrdy_n;
            r_err       <= w_err_n;
        end
    end

    assign o_data_bus    = r_data;
    assign o_data_oe     = r_oe;
    assign o_DBEN        = r_dben;
    assign o_MRDY        = r_mrdy;
    assign o_ce          = r_ce;
    assign o_wr_strobe   = r_strobe;
    assign o_wdata       = r_wdata;
    assign o_region_idx  = r_idx;
    assign o_timeout_err = r_err;

endmodule

// File: tb/tb_mtl_bus_bridge.sv
// Self-checking bench for mtl_bus_bridge: emulates 6809 E/Q cycles and peripherals,
// comparing against a map/handshake reference model.
module tb_mtl_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] i_ADDRESS_BUS;
    logic        i_RW;
    logic        i_E;
    logic        i_Q;
    logic [7:0]  i_data_bus;
    logic [7:0]  o_data_bus;
    logic        o_data_oe;
    logic        o_DBEN;
    logic        o_MRDY;
    logic [3:0]  o_ce;
    logic [3:0]  o_wr_strobe;
    logic [7:0]  o_wdata;
    logic [3:0]  i_ready;
    logic [31:0] i_rdata;
    logic [1:0]  o_region_idx;
    logic        o_timeout_err;
    logic        i_err_clr;

    int checks = 0;
    int errors = 0;

    localparam int TMO = 255;

    mtl_bus_bridge dut (
        .clk(clk), .reset(reset),
        .i_ADDRESS_BUS(i_ADDRESS_BUS), .i_RW(i_RW), .i_E(i_E), .i_Q(i_Q),
        .i_data_bus(i_data_bus), .o_data_bus(o_data_bus), .o_data_oe(o_data_oe),
        .o_DBEN(o_DBEN), .o_MRDY(o_MRDY), .o_ce(o_ce), .o_wr_strobe(o_wr_strobe),
        .o_wdata(o_wdata), .i_ready(i_ready), .i_rdata(i_rdata),
        .o_region_idx(o_region_idx), .o_timeout_err(o_timeout_err), .i_err_clr(i_err_clr)
    );

    always #5 clk = ~clk;

    // Reference map, lowest index first; -1 means unmapped.
    function automatic int modelRegion(input logic [15:0] a);
        logic [15:0] base;
        logic [15:0] mask;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       begin base = 16'h0000; mask = 16'hF000; end
                1:       begin base = 16'hA000; mask = 16'hE000; end
                2:       begin base = 16'hA000; mask = 16'hFFF0; end
                default: begin base = 16'hF000; mask = 16'hF000; end
            endcase
            if ((a & mask) == base) return i;
        end
        return -1;
    endfunction

    logic [7:0] rdSlice [4];
    logic       modelErr;

    bit         obsSeen, obsHang;
    logic [3:0] obsCe, obsStrobeVal, obsEndCe;
    logic [1:0] obsIdx;
    int         obsLow, obsStrobes, obsViol, obsUnm, obsOeWr;
    logic [7:0] obsData, obsWdata, obsEndData;
    logic       obsOe, obsDben, obsErr, obsEndOe, obsEndDben;

    // One 6809 bus cycle: Q rises, then E; peripheral ready after d clocks of o_ce; clr pulse at clrAt.
    task automatic run_access(input logic [15:0] addr, input logic rw, input logic [7:0] wd,
                              input int d, input int clrAt);
        int  ridx;
        int  n;
        bit  done;
        ridx = modelRegion(addr);
        obsSeen = 0; obsHang = 0; obsCe = 0; obsIdx = 0; obsLow = 0; obsStrobes = 0;
        obsStrobeVal = 0; obsWdata = 0; obsViol = 0; obsUnm = 0; obsOeWr = 0;
        for (int s = 0; s < 4; s++) i_rdata[s*8 +: 8] = rdSlice[s];
        i_ADDRESS_BUS = addr; i_RW = rw; i_data_bus = wd;
        @(negedge clk); @(negedge clk);
        i_Q = 1'b1;
        @(negedge clk); @(negedge clk);
        i_E = 1'b1;
        n = 0; done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            i_err_clr = 1'b0;
            if ($countones(o_ce) > 1) obsViol++;
            if ((o_wr_strobe & ~o_ce) != 0) obsViol++;
            if (!rw && o_data_oe) obsOeWr++;
            if (ridx < 0) begin
                if (o_ce != 0 || o_MRDY !== 1'b1 || o_DBEN !== 1'b1 || o_data_oe !== 1'b0) obsUnm++;
                if (c >= 20) done = 1;
            end else begin
                if (!o_MRDY) obsLow++;
                if (!obsSeen && o_ce != 0) begin
                    obsSeen = 1; obsCe = o_ce; obsIdx = o_region_idx;
                end
                if (obsSeen) begin
                    if (obsLow > 0 && o_MRDY) done = 1;
                    else begin
                        if (n >= d) i_ready = 4'(1 << ridx);
                        if (n == clrAt) i_err_clr = 1'b1;
                        n++;
                    end
                end
            end
        end
        if (!done) obsHang = 1;
        i_err_clr = 1'b0;
        @(negedge clk); @(negedge clk);
        obsData = o_data_bus; obsOe = o_data_oe; obsDben = o_DBEN; obsErr = o_timeout_err;
        i_Q = 1'b0;
        @(negedge clk);
        i_E = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if ($countones(o_ce) > 1) obsViol++;
            if ((o_wr_strobe & ~o_ce) != 0) obsViol++;
            if (!rw && o_data_oe) obsOeWr++;
            if (o_wr_strobe != 0) begin
                obsStrobes++; obsStrobeVal = o_wr_strobe; obsWdata = o_wdata;
            end
        end
        obsEndCe = o_ce; obsEndOe = o_data_oe; obsEndDben = o_DBEN; obsEndData = o_data_bus;
        i_ready = '0;
        if (ridx >= 0 && d >= TMO) modelErr = 1'b1;
        else if (ridx >= 0 && clrAt >= 0) modelErr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_ADDRESS_BUS = '0; i_RW = 1'b1; i_E = 1'b0; i_Q = 1'b0;
        i_data_bus = '0; i_ready = '0; i_rdata = '0; i_err_clr = 1'b0; modelErr = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (o_MRDY !== 1'b1) begin errors++; $display("[TB] FAIL rst_mrdy: got %b expected 1", o_MRDY); end
        checks++; if (o_DBEN !== 1'b1) begin errors++; $display("[TB] FAIL rst_dben: got %b expected 1", o_DBEN); end
        checks++; if (o_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL rst_oe: got %b expected 0", o_data_oe); end
        checks++; if (o_data_bus !== 8'h00) begin errors++; $display("[TB] FAIL rst_data: got %h expected 00", o_data_bus); end
        checks++; if (o_ce !== 4'h0) begin errors++; $display("[TB] FAIL rst_ce: got %b expected 0000", o_ce); end
        checks++; if (o_wr_strobe !== 4'h0) begin errors++; $display("[TB] FAIL rst_strobe: got %b expected 0000", o_wr_strobe); end
        checks++; if (o_wdata !== 8'h00) begin errors++; $display("[TB] FAIL rst_wdata: got %h expected 00", o_wdata); end
        checks++; if (o_region_idx !== 2'd0) begin errors++; $display("[TB] FAIL rst_idx: got %0d expected 0", o_region_idx); end
        checks++; if (o_timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b expected 0", o_timeout_err); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read_wait();
        for (int s = 0; s < 4; s++) rdSlice[s] = 8'($urandom);
        rdSlice[3] = 8'h5A;
        run_access(16'hF123, 1'b1, 8'h00, 4, -1);
        checks++; if (obsHang || obsCe !== 4'b1000) begin errors++; $display("[TB] FAIL rd_ce: got %b hang %0d expected 1000", obsCe, obsHang); end
        checks++; if (obsIdx !== 2'd3) begin errors++; $display("[TB] FAIL rd_idx: got %0d expected 3", obsIdx); end
        checks++; if (obsLow != 5) begin errors++; $display("[TB] FAIL rd_mrdy_low: got %0d expected 5", obsLow); end
        checks++; if (obsData !== 8'h5A) begin errors++; $display("[TB] FAIL rd_data: got %h expected 5a", obsData); end
        checks++; if (obsOe !== 1'b1 || obsDben !== 1'b0) begin errors++; $display("[TB] FAIL rd_drive: got oe %b dben %b expected 1 0", obsOe, obsDben); end
        checks++; if (obsEndCe !== 4'h0 || obsEndOe !== 1'b0 || obsEndDben !== 1'b1) begin errors++; $display("[TB] FAIL rd_end: got ce %b oe %b dben %b expected 0000 0 1", obsEndCe, obsEndOe, obsEndDben); end
        checks++; if (obsEndData !== 8'h5A) begin errors++; $display("[TB] FAIL rd_hold: got %h expected 5a", obsEndData); end
        checks++; if (obsViol != 0 || obsStrobes != 0) begin errors++; $display("[TB] FAIL rd_inv: got viol %0d strobes %0d expected 0 0", obsViol, obsStrobes); end
    endtask

    task automatic test_write();
        run_access(16'h0010, 1'b0, 8'hC3, 0, -1);
        checks++; if (obsStrobes != 1 || obsStrobeVal !== 4'b0001) begin errors++; $display("[TB] FAIL wr_strobe: got %0d pulses %b expected 1 0001", obsStrobes, obsStrobeVal); end
        checks++; if (obsWdata !== 8'hC3) begin errors++; $display("[TB] FAIL wr_data: got %h expected c3", obsWdata); end
        checks++; if (obsOeWr != 0) begin errors++; $display("[TB] FAIL wr_oe: got %0d oe cycles expected 0", obsOeWr); end
        checks++; if (obsLow != 1 || obsViol != 0) begin errors++; $display("[TB] FAIL wr_low: got %0d viol %0d expected 1 0", obsLow, obsViol); end
    endtask

    task automatic test_overlap();
        for (int s = 0; s < 4; s++) rdSlice[s] = 8'($urandom);
        run_access(16'hA004, 1'b1, 8'h00, 2, -1);
        checks++; if (obsCe !== 4'b0010 || obsIdx !== 2'd1) begin errors++; $display("[TB] FAIL ovl_ce: got %b idx %0d expected 0010 1", obsCe, obsIdx); end
        checks++; if (obsData !== rdSlice[1]) begin errors++; $display("[TB] FAIL ovl_data: got %h expected %h", obsData, rdSlice[1]); end
    endtask

    task automatic test_unmapped();
        run_access(16'h8000, 1'b1, 8'h00, 0, -1);
        checks++; if (obsUnm != 0) begin errors++; $display("[TB] FAIL unm_idle: got %0d bad cycles expected 0", obsUnm); end
        checks++; if (obsEndCe !== 4'h0 || obsStrobes != 0) begin errors++; $display("[TB] FAIL unm_end: got ce %b strobes %0d expected 0000 0", obsEndCe, obsStrobes); end
    endtask

    task automatic test_timeout();
        for (int s = 0; s < 4; s++) rdSlice[s] = 8'($urandom_range(0, 254));
        run_access(16'hB000, 1'b1, 8'h00, 1000, -1);
        checks++; if (obsHang || obsLow != TMO) begin errors++; $display("[TB] FAIL to_low: got %0d hang %0d expected %0d", obsLow, obsHang, TMO); end
        checks++; if (obsData !== 8'hFF) begin errors++; $display("[TB] FAIL to_data: got %h expected ff", obsData); end
        checks++; if (obsErr !== modelErr) begin errors++; $display("[TB] FAIL to_err: got %b expected %b", obsErr, modelErr); end
        repeat (5) @(negedge clk);
        checks++; if (o_timeout_err !== modelErr) begin errors++; $display("[TB] FAIL to_sticky: got %b expected %b", o_timeout_err, modelErr); end
        i_err_clr = 1'b1; @(negedge clk); i_err_clr = 1'b0; modelErr = 1'b0;
        checks++; if (o_timeout_err !== modelErr) begin errors++; $display("[TB] FAIL to_clr: got %b expected %b", o_timeout_err, modelErr); end
        run_access(16'hB000, 1'b1, 8'h00, TMO - 1, -1);
        checks++; if (obsLow != TMO || obsData !== rdSlice[1]) begin errors++; $display("[TB] FAIL to_edge_ready: got low %0d data %h expected %0d %h", obsLow, obsData, TMO, rdSlice[1]); end
        checks++; if (obsErr !== modelErr) begin errors++; $display("[TB] FAIL to_edge_err: got %b expected %b", obsErr, modelErr); end
        run_access(16'h0020, 1'b0, 8'h77, 1000, -1);
        checks++; if (obsStrobes != 0 || obsErr !== modelErr) begin errors++; $display("[TB] FAIL to_wr: got strobes %0d err %b expected 0 %b", obsStrobes, obsErr, modelErr); end
        run_access(16'hB000, 1'b1, 8'h00, 1000, TMO - 1);
        checks++; if (obsErr !== modelErr) begin errors++; $display("[TB] FAIL to_set_clr: got %b expected %b", obsErr, modelErr); end
        i_err_clr = 1'b1; @(negedge clk); i_err_clr = 1'b0; modelErr = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        int waited;
        i_ADDRESS_BUS = 16'hF123; i_RW = 1'b1;
        i_Q = 1'b1; @(negedge clk); @(negedge clk); i_E = 1'b1;
        waited = 0;
        while (o_ce == 0 && waited < 20) begin @(negedge clk); waited++; end
        repeat (3) @(negedge clk);
        checks++; if (o_MRDY !== 1'b0) begin errors++; $display("[TB] FAIL rma_pre: got mrdy %b expected 0", o_MRDY); end
        reset = 1'b1; i_E = 1'b0; i_Q = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (o_MRDY !== 1'b1 || o_ce !== 4'h0) begin errors++; $display("[TB] FAIL rma_reset: got mrdy %b ce %b expected 1 0000", o_MRDY, o_ce); end
        checks++; if (o_data_oe !== 1'b0 || o_DBEN !== 1'b1) begin errors++; $display("[TB] FAIL rma_bus: got oe %b dben %b expected 0 1", o_data_oe, o_DBEN); end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) rdSlice[s] = 8'($urandom);
        run_access(16'h0ABC, 1'b1, 8'h00, 3, -1);
        checks++; if (obsCe !== 4'b0001 || obsLow != 4 || obsData !== rdSlice[0]) begin errors++; $display("[TB] FAIL rma_next: got ce %b low %0d data %h expected 0001 4 %h", obsCe, obsLow, obsData, rdSlice[0]); end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic        rw;
        logic [7:0]  wd;
        int          d;
        int          r;
        for (int it = 0; it < 12; it++) begin
            a = 16'($urandom); rw = 1'($urandom); wd = 8'($urandom); d = $urandom_range(0, 10);
            for (int s = 0; s < 4; s++) rdSlice[s] = 8'($urandom);
            r = modelRegion(a);
            run_access(a, rw, wd, d, -1);
            if (r < 0) begin
                checks++; if (obsUnm != 0 || obsSeen) begin errors++; $display("[TB] FAIL rnd_unm a=%h: got %0d bad cycles expected 0", a, obsUnm); end
            end else begin
                checks++; if (obsHang || obsIdx !== 2'(r) || obsCe !== 4'(1 << r)) begin errors++; $display("[TB] FAIL rnd_sel a=%h: got ce %b idx %0d expected idx %0d", a, obsCe, obsIdx, r); end
                checks++; if (obsLow != d + 1) begin errors++; $display("[TB] FAIL rnd_low a=%h: got %0d expected %0d", a, obsLow, d + 1); end
                if (rw) begin
                    checks++; if (obsData !== rdSlice[r] || obsOe !== 1'b1 || obsDben !== 1'b0) begin errors++; $display("[TB] FAIL rnd_rd a=%h: got %h oe %b dben %b expected %h 1 0", a, obsData, obsOe, obsDben, rdSlice[r]); end
                end else begin
                    checks++; if (obsStrobes != 1 || obsStrobeVal !== 4'(1 << r) || obsWdata !== wd) begin errors++; $display("[TB] FAIL rnd_wr a=%h: got %0d pulses %b data %h expected 1 pulse data %h", a, obsStrobes, obsStrobeVal, obsWdata, wd); end
                end
                checks++; if (obsViol != 0 || obsEndCe !== 4'h0 || obsEndDben !== 1'b1 || obsErr !== modelErr) begin errors++; $display("[TB] FAIL rnd_end a=%h: got viol %0d ce %b dben %b err %b expected 0 0000 1 %b", a, obsViol, obsEndCe, obsEndDben, obsErr, modelErr); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_wait();
        test_write();
        test_overlap();
        test_unmapped();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
